rdata_demux_grp: RTL and testbench

- Parametrised AXI read-data demultiplexer for the macroblock fetch path.
- After each start_pulse, the first accepted beat is captured as the job header (quantiser/lambda parameter block).
- Each following group of NUM_CH beats is staged, then written atomically into NUM_CH downstream FIFOs.
- Adds per-FIFO backpressure, burst-alignment checking, sticky error reporting and a group counter.

---
 rtl/rdata_pkg.sv | 17 +
 rtl/rdata_demux_grp_if.sv | 24 ++
 rtl/rdata_demux_grp.sv | 155 +++++++++++++++
 tb/tb_rdata_demux_grp.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rdata_pkg.sv
// Shared definitions for the read-data demultiplexer: response codes,
// FSM state encoding and the beat-index width helper.
package rdata_pkg;

  localparam logic [1:0] RRESP_OKAY = 2'b00;

  typedef enum logic [0:0] {
    S_HDR = 1'b0,
    S_GRP = 1'b1
  } state_e;

  // Width of the beat index that counts 0..n-1 within a group.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rdata_demux_grp_if.sv
// AXI read-data channel as seen by the demultiplexer.
// master: the demux side (consumes beats, drives rready).
// slave : the memory/interconnect side (drives beats).
interface rdata_demux_grp_if #(
  parameter int DATA_W   = 1024,
  parameter int ID_WIDTH = 2
);
  logic [DATA_W-1:0]   rdata;
  logic [ID_WIDTH-1:0] rid;
  logic                rlast;
  logic                rvalid;
  logic [1:0]          rresp;
  logic                rready;

  modport master (
    input  rdata, rid, rlast, rvalid, rresp,
    output rready
  );

  modport slave (
    output rdata, rid, rlast, rvalid, rresp,
    input  rready
  );
endinterface

// File: rtl/rdata_demux_grp.sv
// Read-data demultiplexer for the macroblock fetch path.
// First beat after start_pulse is the job header; every following group of
// NUM_CH beats is written atomically, one word per downstream FIFO.
// Optional build macro: RDATA_DEMUX_ID_CHECK_EN (rid consistency check,
// adds the id_err output).
//
// state | meaning
// ------+--------------------------------------------
// S_HDR | waiting for the header beat of a new job
// S_GRP | collecting group beats, idx = next slot
module rdata_demux_grp
  import rdata_pkg::*;
#(
  parameter int DATA_W   = 1024,
  parameter int ID_WIDTH = 2,
  parameter int NUM_CH   = 3,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rdata_demux_grp_if.master        axi,
  input  logic                     start_pulse,
  output logic [DATA_W-1:0]        hdr_data,
  output logic                     hdr_valid,
  output logic [NUM_CH*DATA_W-1:0] fifo_din,
  input  logic [NUM_CH-1:0]        fifo_full,
  output logic [NUM_CH-1:0]        fifo_wr,
  output logic [CNT_W-1:0]         grp_cnt,
  output logic                     resp_err,
`ifdef RDATA_DEMUX_ID_CHECK_EN
  output logic                     id_err,
`endif
  output logic                     proto_err
);

  localparam int IDX_W = idx_w(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  state_e            state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] stage [NUM_CH-1];
  logic              beat_acc;
  logic              last_slot;
  logic              grp_done;
  logic              misalign;

  assign last_slot = (state == S_GRP) && (idx == LAST_IDX);

  // Beat acceptance: the closing beat of a group waits until every FIFO has room
  always_comb begin
    axi.rready = 1'b0;
    if (start_pulse)
      axi.rready = 1'b0;
    else if (state == S_HDR)
      axi.rready = 1'b1;
    else if (!last_slot)
      axi.rready = 1'b1;
    else
      axi.rready = ~|fifo_full;
  end

  assign beat_acc = axi.rvalid & axi.rready;
  assign grp_done = beat_acc & last_slot;
  assign misalign = beat_acc & (state == S_GRP) & ~last_slot & axi.rlast;

  assign fifo_wr = {NUM_CH{grp_done}};

  // Slots 0..NUM_CH-2 from staging, last slot is the live beat
  genvar k;
  generate
    for (k = 0; k < NUM_CH - 1; k++) begin : g_slot
      assign fifo_din[k*DATA_W +: DATA_W] = stage[k];
    end
  endgenerate
  assign fifo_din[(NUM_CH-1)*DATA_W +: DATA_W] = axi.rdata;

  // Staging of group beats; a misaligned (rlast) beat is never stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_CH - 1; s++)
        stage[s] <= '0;
    end else if (beat_acc && (state == S_GRP) && !last_slot && !axi.rlast) begin
      for (int s = 0; s < NUM_CH - 1; s++)
        if (idx == IDX_W'(s))
          stage[s] <= axi.rdata;
    end
  end

`ifdef RDATA_DEMUX_ID_CHECK_EN
  logic [ID_WIDTH-1:0] rid_q;
  logic                id_bad;

  assign id_bad = beat_acc & (state == S_GRP) & (axi.rid != rid_q);

  // Header rid reference and sticky id mismatch flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rid_q  <= '0;
      id_err <= 1'b0;
    end else if (start_pulse) begin
      id_err <= 1'b0;
    end else begin
      if (beat_acc && (state == S_HDR))
        rid_q <= axi.rid;
      if (id_bad)
        id_err <= 1'b1;
    end
  end
`else
  logic id_bad;
  logic unused_rid;

  assign id_bad     = 1'b0;
  assign unused_rid = ^axi.rid;
`endif

  // FSM, header capture, group counter and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HDR;
      idx       <= '0;
      hdr_data  <= '0;
      hdr_valid <= 1'b0;
      grp_cnt   <= '0;
      resp_err  <= 1'b0;
      proto_err <= 1'b0;
    end else if (start_pulse) begin
      state     <= S_HDR;
      idx       <= '0;
      hdr_valid <= 1'b0;
      grp_cnt   <= '0;
      resp_err  <= 1'b0;
      proto_err <= 1'b0;
    end else if (beat_acc) begin
      if (axi.rresp != RRESP_OKAY)
        resp_err <= 1'b1;
      if (misalign || id_bad)
        proto_err <= 1'b1;
      if (state == S_HDR) begin
        hdr_data  <= axi.rdata;
        hdr_valid <= 1'b1;
        state     <= S_GRP;
        idx       <= '0;
      end else if (last_slot) begin
        idx     <= '0;
        grp_cnt <= grp_cnt + 1'b1;
      end else if (axi.rlast) begin
        idx <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rdata_demux_grp.sv
// Directed self-checking bench for rdata_demux_grp (DATA_W=64, NUM_CH=3).
`timescale 1ns/1ps
module tb_rdata_demux_grp;
  localparam int DW = 64;
  localparam int NC = 3;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_pulse = 1'b0;
  logic [DW-1:0]    hdr_data;
  logic             hdr_valid;
  logic [NC*DW-1:0] fifo_din;
  logic [NC-1:0]    fifo_full = '0;
  logic [NC-1:0]    fifo_wr;
  logic [CW-1:0]    grp_cnt;
  logic             resp_err;
  logic             proto_err;
`ifdef RDATA_DEMUX_ID_CHECK_EN
  logic             id_err;
`endif

  int checks = 0;
  int errors = 0;

  int               wr_cnt = 0;
  int               bad_wr = 0;
  logic [NC*DW-1:0] wr_din = '0;

  rdata_demux_grp_if #(.DATA_W(DW), .ID_WIDTH(2)) axi_if ();

  rdata_demux_grp #(.DATA_W(DW), .ID_WIDTH(2), .NUM_CH(NC), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .axi         (axi_if),
    .start_pulse (start_pulse),
    .hdr_data    (hdr_data),
    .hdr_valid   (hdr_valid),
    .fifo_din    (fifo_din),
    .fifo_full   (fifo_full),
    .fifo_wr     (fifo_wr),
    .grp_cnt     (grp_cnt),
    .resp_err    (resp_err),
`ifdef RDATA_DEMUX_ID_CHECK_EN
    .id_err      (id_err),
`endif
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  // Record FIFO write cycles (sampled mid-cycle)
  always @(negedge clk) begin
    if (fifo_wr !== '0) begin
      wr_cnt = wr_cnt + 1;
      wr_din = fifo_din;
      if (fifo_wr !== 3'b111) bad_wr = bad_wr + 1;
    end
  end

  task automatic pulse_start();
    start_pulse = 1'b1;
    @(posedge clk); #1;
    start_pulse = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic last,
                           input logic [1:0] resp, input logic [1:0] id);
    int n;
    axi_if.rdata  = d;
    axi_if.rlast  = last;
    axi_if.rresp  = resp;
    axi_if.rid    = id;
    axi_if.rvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (axi_if.rready !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (axi_if.rready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_beat_timeout data=%h rready=%b want 1", d, axi_if.rready);
    end
    @(posedge clk); #1;
    axi_if.rvalid = 1'b0;
    axi_if.rlast  = 1'b0;
    axi_if.rresp  = 2'b00;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (hdr_valid !== 1'b0) begin errors++; $display("FAIL rst_hdr_valid got %b want 0", hdr_valid); end
    checks++; if (hdr_data !== '0) begin errors++; $display("FAIL rst_hdr_data got %h want 0", hdr_data); end
    checks++; if (grp_cnt !== '0) begin errors++; $display("FAIL rst_grp_cnt got %0d want 0", grp_cnt); end
    checks++; if (resp_err !== 1'b0 || proto_err !== 1'b0) begin errors++; $display("FAIL rst_errs got %b%b want 00", resp_err, proto_err); end
    checks++; if (fifo_wr !== 3'b000) begin errors++; $display("FAIL rst_fifo_wr got %b want 000", fifo_wr); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (axi_if.rready !== 1'b1) begin errors++; $display("FAIL rst_rready got %b want 1", axi_if.rready); end
  endtask

  task automatic test_nominal();
    int w0;
    pulse_start();
    send_beat(64'hA0, 1'b0, 2'b00, 2'd0);
    checks++; if (hdr_data !== 64'hA0) begin errors++; $display("FAIL nom_hdr_data got %h want a0", hdr_data); end
    checks++; if (hdr_valid !== 1'b1) begin errors++; $display("FAIL nom_hdr_valid got %b want 1", hdr_valid); end
    w0 = wr_cnt;
    send_beat(64'h01, 1'b0, 2'b00, 2'd0);
    send_beat(64'h02, 1'b0, 2'b00, 2'd0);
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL nom_early_wr got %0d want %0d", wr_cnt, w0); end
    send_beat(64'h03, 1'b1, 2'b00, 2'd0);
    checks++; if (wr_cnt !== w0 + 1) begin errors++; $display("FAIL nom_wr_count got %0d want %0d", wr_cnt, w0 + 1); end
    checks++; if (wr_din !== {64'h03, 64'h02, 64'h01}) begin errors++; $display("FAIL nom_fifo_din got %h want 3/2/1", wr_din); end
    checks++; if (grp_cnt !== 16'd1) begin errors++; $display("FAIL nom_grp_cnt got %0d want 1", grp_cnt); end
    checks++; if (proto_err !== 1'b0 || bad_wr !== 0) begin errors++; $display("FAIL nom_proto got %b bad_wr %0d want 0 0", proto_err, bad_wr); end
  endtask

  task automatic test_backpressure();
    int w0;
    w0 = wr_cnt;
    send_beat(64'h11, 1'b0, 2'b00, 2'd0);
    send_beat(64'h12, 1'b0, 2'b00, 2'd0);
    fifo_full = 3'b010;
    axi_if.rdata = 64'h13; axi_if.rlast = 1'b1; axi_if.rresp = 2'b00; axi_if.rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (axi_if.rready !== 1'b0 || fifo_wr !== 3'b000) begin errors++; $display("FAIL bp_stall rready %b wr %b want 0 000", axi_if.rready, fifo_wr); end
    end
    @(posedge clk); #1;
    fifo_full = 3'b000;
    @(negedge clk);
    checks++; if (axi_if.rready !== 1'b1 || fifo_wr !== 3'b111) begin errors++; $display("FAIL bp_release rready %b wr %b want 1 111", axi_if.rready, fifo_wr); end
    @(posedge clk); #1;
    axi_if.rvalid = 1'b0; axi_if.rlast = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (wr_cnt !== w0 + 1) begin errors++; $display("FAIL bp_dup got %0d writes want %0d", wr_cnt - w0, 1); end
    checks++; if (wr_din !== {64'h13, 64'h12, 64'h11}) begin errors++; $display("FAIL bp_fifo_din got %h want 13/12/11", wr_din); end
    checks++; if (grp_cnt !== 16'd2) begin errors++; $display("FAIL bp_grp_cnt got %0d want 2", grp_cnt); end
  endtask

  task automatic test_misalign();
    int w0;
    w0 = wr_cnt;
    send_beat(64'h21, 1'b0, 2'b00, 2'd0);
    send_beat(64'h22, 1'b1, 2'b00, 2'd0);
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL mis_proto got %b want 1", proto_err); end
    checks++; if (wr_cnt !== w0 || grp_cnt !== 16'd2) begin errors++; $display("FAIL mis_nowr writes %0d cnt %0d want 0 2", wr_cnt - w0, grp_cnt); end
    send_beat(64'h31, 1'b0, 2'b00, 2'd0);
    send_beat(64'h32, 1'b0, 2'b00, 2'd0);
    send_beat(64'h33, 1'b1, 2'b00, 2'd0);
    checks++; if (wr_cnt !== w0 + 1 || wr_din !== {64'h33, 64'h32, 64'h31}) begin errors++; $display("FAIL mis_resync writes %0d din %h want 1 33/32/31", wr_cnt - w0, wr_din); end
    checks++; if (grp_cnt !== 16'd3 || proto_err !== 1'b1) begin errors++; $display("FAIL mis_sticky cnt %0d proto %b want 3 1", grp_cnt, proto_err); end
  endtask

  task automatic test_resp_err();
    pulse_start();
    checks++; if (proto_err !== 1'b0 || grp_cnt !== '0 || hdr_valid !== 1'b0) begin errors++; $display("FAIL start_clear proto %b cnt %0d hv %b want 0 0 0", proto_err, grp_cnt, hdr_valid); end
    send_beat(64'hB0, 1'b0, 2'b10, 2'd0);
    checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL resp_set got %b want 1", resp_err); end
    for (int g = 0; g < 2; g++) begin
      send_beat(64'h41, 1'b0, 2'b00, 2'd0);
      send_beat(64'h42, 1'b0, 2'b00, 2'd0);
      send_beat(64'h43, 1'b1, 2'b00, 2'd0);
    end
    checks++; if (resp_err !== 1'b1 || grp_cnt !== 16'd2) begin errors++; $display("FAIL resp_sticky err %b cnt %0d want 1 2", resp_err, grp_cnt); end
    pulse_start();
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL resp_clear got %b want 0", resp_err); end
    checks++; if (hdr_data !== 64'hB0) begin errors++; $display("FAIL hdr_keep got %h want b0", hdr_data); end
  endtask

  task automatic test_start_coincident();
    send_beat(64'hC5, 1'b0, 2'b00, 2'd0);
    send_beat(64'h51, 1'b0, 2'b00, 2'd0);
    axi_if.rdata = 64'hC0; axi_if.rlast = 1'b0; axi_if.rresp = 2'b00; axi_if.rvalid = 1'b1;
    start_pulse = 1'b1;
    @(negedge clk);
    checks++; if (axi_if.rready !== 1'b0) begin errors++; $display("FAIL sp_rready got %b want 0", axi_if.rready); end
    @(posedge clk); #1;
    start_pulse = 1'b0;
    @(negedge clk);
    checks++; if (axi_if.rready !== 1'b1 || hdr_valid !== 1'b0) begin errors++; $display("FAIL sp_hdr_state rready %b hv %b want 1 0", axi_if.rready, hdr_valid); end
    @(posedge clk); #1;
    axi_if.rvalid = 1'b0;
    checks++; if (hdr_data !== 64'hC0 || hdr_valid !== 1'b1) begin errors++; $display("FAIL sp_new_hdr got %h hv %b want c0 1", hdr_data, hdr_valid); end
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = wr_cnt;
    for (int g = 0; g < 3; g++) begin
      send_beat(64'h60 + 64'(g * 4) + 64'd1, 1'b0, 2'b00, 2'd0);
      send_beat(64'h60 + 64'(g * 4) + 64'd2, 1'b0, 2'b00, 2'd0);
      send_beat(64'h60 + 64'(g * 4) + 64'd3, 1'b1, 2'b00, 2'd0);
    end
    checks++; if (wr_cnt !== w0 + 3 || grp_cnt !== 16'd3) begin errors++; $display("FAIL b2b_count writes %0d cnt %0d want 3 3", wr_cnt - w0, grp_cnt); end
    checks++; if (wr_din !== {64'h6B, 64'h6A, 64'h69}) begin errors++; $display("FAIL b2b_din got %h want 6b/6a/69", wr_din); end
    checks++; if (bad_wr !== 0 || proto_err !== 1'b0) begin errors++; $display("FAIL b2b_clean bad_wr %0d proto %b want 0 0", bad_wr, proto_err); end
  endtask

`ifdef RDATA_DEMUX_ID_CHECK_EN
  task automatic test_id_check();
    int w0;
    pulse_start();
    w0 = wr_cnt;
    send_beat(64'hD0, 1'b0, 2'b00, 2'd1);
    send_beat(64'h71, 1'b0, 2'b00, 2'd1);
    checks++; if (id_err !== 1'b0) begin errors++; $display("FAIL id_match got %b want 0", id_err); end
    send_beat(64'h72, 1'b0, 2'b00, 2'd2);
    send_beat(64'h73, 1'b1, 2'b00, 2'd1);
    checks++; if (id_err !== 1'b1 || proto_err !== 1'b1) begin errors++; $display("FAIL id_err id %b proto %b want 1 1", id_err, proto_err); end
    checks++; if (wr_cnt !== w0 + 1 || wr_din !== {64'h73, 64'h72, 64'h71}) begin errors++; $display("FAIL id_write writes %0d din %h want 1 73/72/71", wr_cnt - w0, wr_din); end
  endtask
`endif

  initial begin
    axi_if.rdata  = '0;
    axi_if.rid    = '0;
    axi_if.rlast  = 1'b0;
    axi_if.rvalid = 1'b0;
    axi_if.rresp  = 2'b00;
    test_reset();
    test_nominal();
    test_backpressure();
    test_misalign();
    test_resp_err();
    test_start_coincident();
    test_back_to_back();
`ifdef RDATA_DEMUX_ID_CHECK_EN
    test_id_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
